// File: rtl/operand_streamer_pkg.sv
// Shared types and default widths for the operand pair streamer.
// Holds the streamer state enum and the default width constants.
package operand_streamer_pkg;

    localparam int BITMASK_LENGTH = 8;
    localparam int INDEX_BITWIDTH = 3;
    localparam int COUNT_BITWIDTH = 4;
    localparam int VALUE_BITWIDTH = 8;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_e;

endpackage

// File: rtl/operand_pair_streamer_value_select.sv
// operand_value_select: combinational BITMASK_LENGTH:1 value mux.
// Ports: values_i packed value slots, idx_i slot index, value_o selected slot.
module operand_value_select #(
    parameter int BITMASK_LENGTH = 8,
    parameter int INDEX_BITWIDTH = 3,
    parameter int VALUE_BITWIDTH = 8
) (
    input  logic [BITMASK_LENGTH*VALUE_BITWIDTH-1:0] values_i,
    input  logic [INDEX_BITWIDTH-1:0]                idx_i,
    output logic [VALUE_BITWIDTH-1:0]                value_o
);

    always_comb begin
        value_o = '0;
        for (int j = 0; j < BITMASK_LENGTH; j++) begin
            if (idx_i == INDEX_BITWIDTH'(j)) begin
                value_o = values_i[j*VALUE_BITWIDTH +: VALUE_BITWIDTH];
            end
        end
    end

endmodule

// File: rtl/operand_pair_streamer.sv
// operand_pair_streamer: turns a match-result block into one
// (activation, weight) pair beat per cycle under valid/ready.
// Ports: clock/resetn (async active-low); in_* block handshake + data;
// out_* registered beat (act, wgt, pos, last) with valid/ready.
// Option macro: OPERAND_STREAMER_PREFETCH_EN (accept next block on last beat).
module operand_pair_streamer
    import operand_streamer_pkg::*;
#(
    parameter int BITMASK_LENGTH = operand_streamer_pkg::BITMASK_LENGTH,
    parameter int INDEX_BITWIDTH = operand_streamer_pkg::INDEX_BITWIDTH,
    parameter int COUNT_BITWIDTH = operand_streamer_pkg::COUNT_BITWIDTH,
    parameter int VALUE_BITWIDTH = operand_streamer_pkg::VALUE_BITWIDTH
) (
    input  logic                                     clock,
    input  logic                                     resetn,
    input  logic                                     in_valid,
    output logic                                     in_ready,
    input  logic [COUNT_BITWIDTH-1:0]                in_count,
    input  logic [BITMASK_LENGTH*INDEX_BITWIDTH-1:0] in_idx_a,
    input  logic [BITMASK_LENGTH*INDEX_BITWIDTH-1:0] in_idx_w,
    input  logic [BITMASK_LENGTH*VALUE_BITWIDTH-1:0] in_values_a,
    input  logic [BITMASK_LENGTH*VALUE_BITWIDTH-1:0] in_values_w,
    output logic                                     out_valid,
    input  logic                                     out_ready,
    output logic [VALUE_BITWIDTH-1:0]                out_act,
    output logic [VALUE_BITWIDTH-1:0]                out_wgt,
    output logic [INDEX_BITWIDTH-1:0]                out_pos,
    output logic                                     out_last
);

    localparam int IW = INDEX_BITWIDTH;
    localparam int CW = COUNT_BITWIDTH;
    localparam int VW = VALUE_BITWIDTH;
    localparam int BL = BITMASK_LENGTH;

    state_e              state_q, state_d;
    logic [BL*IW-1:0]    idx_a_q, idx_a_d;
    logic [BL*IW-1:0]    idx_w_q, idx_w_d;
    logic [BL*VW-1:0]    vals_a_q, vals_a_d;
    logic [BL*VW-1:0]    vals_w_q, vals_w_d;
    logic [CW-1:0]       n_q, n_d;
    logic                valid_q, valid_d;
    logic [VW-1:0]       act_q, act_d;
    logic [VW-1:0]       wgt_q, wgt_d;
    logic [IW-1:0]       pos_q, pos_d;
    logic                last_q, last_d;

    logic                accept;
    logic                advance;
    logic [CW-1:0]       n_in;
    logic [IW-1:0]       nxt_pos;
    logic [IW-1:0]       ia_arr [BL];
    logic [IW-1:0]       iw_arr [BL];
    logic [IW-1:0]       sel_idx_a, sel_idx_w;
    logic [BL*VW-1:0]    sel_vals_a, sel_vals_w;
    logic [VW-1:0]       sel_a, sel_w;

    for (genvar g = 0; g < BL; g++) begin : g_unpack
        assign ia_arr[g] = idx_a_q[g*IW +: IW];
        assign iw_arr[g] = idx_w_q[g*IW +: IW];
    end

`ifdef OPERAND_STREAMER_PREFETCH_EN
    // Next block may land while the last beat drains.
    assign in_ready = (state_q == IDLE) || (last_q && out_ready);
`else
    assign in_ready = (state_q == IDLE);
`endif

    assign accept  = in_valid && in_ready;
    assign advance = valid_q && out_ready;
    assign n_in    = (in_count > CW'(BL)) ? CW'(BL) : in_count;
    assign nxt_pos = pos_q + IW'(1);

    // One mux pair serves both beat 0 of a new block (from the inputs)
    // and beat k+1 of the held block.
    assign sel_idx_a  = accept ? in_idx_a[IW-1:0] : ia_arr[nxt_pos];
    assign sel_idx_w  = accept ? in_idx_w[IW-1:0] : iw_arr[nxt_pos];
    assign sel_vals_a = accept ? in_values_a : vals_a_q;
    assign sel_vals_w = accept ? in_values_w : vals_w_q;

    operand_value_select #(
        .BITMASK_LENGTH (BL),
        .INDEX_BITWIDTH (IW),
        .VALUE_BITWIDTH (VW)
    ) u_sel_a (
        .values_i (sel_vals_a),
        .idx_i    (sel_idx_a),
        .value_o  (sel_a)
    );

    operand_value_select #(
        .BITMASK_LENGTH (BL),
        .INDEX_BITWIDTH (IW),
        .VALUE_BITWIDTH (VW)
    ) u_sel_w (
        .values_i (sel_vals_w),
        .idx_i    (sel_idx_w),
        .value_o  (sel_w)
    );

    always_comb begin
        state_d  = state_q;
        idx_a_d  = idx_a_q;
        idx_w_d  = idx_w_q;
        vals_a_d = vals_a_q;
        vals_w_d = vals_w_q;
        n_d      = n_q;
        valid_d  = valid_q;
        act_d    = act_q;
        wgt_d    = wgt_q;
        pos_d    = pos_q;
        last_d   = last_q;
        if (accept) begin
            state_d  = STREAM;
            idx_a_d  = in_idx_a;
            idx_w_d  = in_idx_w;
            vals_a_d = in_values_a;
            vals_w_d = in_values_w;
            n_d      = n_in;
            valid_d  = 1'b1;
            pos_d    = '0;
            // Empty block still emits one zero beat to close the MAC.
            act_d    = (n_in == '0) ? '0 : sel_a;
            wgt_d    = (n_in == '0) ? '0 : sel_w;
            last_d   = (n_in <= CW'(1));
        end else if (advance) begin
            if (last_q) begin
                state_d = IDLE;
                valid_d = 1'b0;
            end else begin
                pos_d  = nxt_pos;
                act_d  = sel_a;
                wgt_d  = sel_w;
                last_d = (CW'(nxt_pos) == n_q - CW'(1));
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            idx_a_q  <= '0;
            idx_w_q  <= '0;
            vals_a_q <= '0;
            vals_w_q <= '0;
            n_q      <= '0;
            valid_q  <= 1'b0;
            act_q    <= '0;
            wgt_q    <= '0;
            pos_q    <= '0;
            last_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_a_q  <= idx_a_d;
            idx_w_q  <= idx_w_d;
            vals_a_q <= vals_a_d;
            vals_w_q <= vals_w_d;
            n_q      <= n_d;
            valid_q  <= valid_d;
            act_q    <= act_d;
            wgt_q    <= wgt_d;
            pos_q    <= pos_d;
            last_q   <= last_d;
        end
    end

    assign out_valid = valid_q;
    assign out_act   = act_q;
    assign out_wgt   = wgt_q;
    assign out_pos   = pos_q;
    assign out_last  = last_q;

endmodule

// File: tb/tb_operand_pair_streamer.sv
// Self-checking bench for operand_pair_streamer: vector table,
// scoreboard of expected beats, and hand-written corner sequences.
module tb_operand_pair_streamer;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_count = '0;
    logic [23:0] in_idx_a = '0;
    logic [23:0] in_idx_w = '0;
    logic [63:0] in_values_a = '0;
    logic [63:0] in_values_w = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [7:0]  out_act;
    logic [7:0]  out_wgt;
    logic [2:0]  out_pos;
    logic        out_last;

    always #5 clock = ~clock;

    operand_pair_streamer dut (
        .clock       (clock),
        .resetn      (resetn),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_count    (in_count),
        .in_idx_a    (in_idx_a),
        .in_idx_w    (in_idx_w),
        .in_values_a (in_values_a),
        .in_values_w (in_values_w),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_act     (out_act),
        .out_wgt     (out_wgt),
        .out_pos     (out_pos),
        .out_last    (out_last)
    );

    typedef struct {
        logic [7:0] act;
        logic [7:0] wgt;
        logic [2:0] pos;
        logic       last;
    } beat_t;

    typedef struct {
        logic [3:0]  cnt;
        logic [23:0] ia;
        logic [23:0] iw;
        int          nbeats;
        logic [7:0]  a0;
        logic [7:0]  w0;
    } vec_t;

    beat_t sb[$];
    logic  vhist[$];
    logic  rec_en = 1'b0;
    int    n_tests = 0;
    int    n_fail = 0;
    int    beats_seen = 0;
    logic [63:0] va, vw;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [23:0] pk(input int e0, e1, e2, e3,
                                       e4, e5, e6, e7);
        return {3'(e7), 3'(e6), 3'(e5), 3'(e4),
                3'(e3), 3'(e2), 3'(e1), 3'(e0)};
    endfunction

    // Scoreboard: push on accept, pop/compare on each beat handshake.
    always @(negedge clock) begin
        if (rec_en) vhist.push_back(out_valid);
        if (resetn && in_valid && in_ready) begin
            int n;
            n = (in_count > 4'd8) ? 8 : int'(in_count);
            if (n == 0) begin
                sb.push_back('{8'h00, 8'h00, 3'd0, 1'b1});
            end else begin
                for (int k = 0; k < n; k++) begin
                    int ia, iw;
                    ia = int'(in_idx_a[k*3 +: 3]);
                    iw = int'(in_idx_w[k*3 +: 3]);
                    sb.push_back('{in_values_a[ia*8 +: 8],
                                   in_values_w[iw*8 +: 8],
                                   3'(k), (k == n-1)});
                end
            end
        end
        if (resetn && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_beat: got pos %0d expected none",
                         out_pos);
            end else begin
                beat_t e;
                e = sb.pop_front();
                chk("beat_act", 32'(out_act), 32'(e.act));
                chk("beat_wgt", 32'(out_wgt), 32'(e.wgt));
                chk("beat_pos", 32'(out_pos), 32'(e.pos));
                chk("beat_last", 32'(out_last), 32'(e.last));
                beats_seen++;
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Returns #1 after the accepting edge.
    task automatic send(input logic [3:0] cnt, input logic [23:0] ia,
                        input logic [23:0] iw);
        logic acc;
        in_count    = cnt;
        in_idx_a    = ia;
        in_idx_w    = iw;
        in_values_a = va;
        in_values_w = vw;
        in_valid    = 1'b1;
        for (int t = 0; t < 40; t++) begin
            @(negedge clock);
            acc = in_ready;
            tick();
            if (acc) begin
                in_valid = 1'b0;
                return;
            end
        end
        in_valid = 1'b0;
        n_tests++;
        n_fail++;
        $display("FAIL accept_timeout: got in_ready 0 expected 1");
    endtask

    task automatic drain();
        for (int t = 0; t < 60; t++) begin
            if (sb.size() == 0 && !out_valid) return;
            tick();
        end
        n_tests++;
        n_fail++;
        $display("FAIL drain_timeout: got %0d pending expected 0",
                 sb.size());
    endtask

    vec_t vecs[6];

    initial begin
        for (int j = 0; j < 8; j++) begin
            va[j*8 +: 8] = 8'(16 + j);
            vw[j*8 +: 8] = 8'(32 + j);
        end
        vecs[0] = '{4'd3,  pk(0,2,5,0,0,0,0,0), pk(1,2,3,0,0,0,0,0),
                    3, 8'h10, 8'h21};
        vecs[1] = '{4'd0,  pk(3,3,3,3,3,3,3,3), pk(4,4,4,4,4,4,4,4),
                    1, 8'h00, 8'h00};
        vecs[2] = '{4'd12, pk(7,6,5,4,3,2,1,0), pk(0,1,2,3,4,5,6,7),
                    8, 8'h17, 8'h20};
        vecs[3] = '{4'd8,  pk(1,1,1,1,1,1,1,1), pk(7,6,7,6,7,6,7,6),
                    8, 8'h11, 8'h27};
        vecs[4] = '{4'd1,  pk(4,0,0,0,0,0,0,0), pk(6,0,0,0,0,0,0,0),
                    1, 8'h14, 8'h26};
        vecs[5] = '{4'd9,  pk(3,1,4,1,5,2,6,5), pk(2,7,1,0,2,3,5,4),
                    8, 8'h13, 8'h22};

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_act", 32'(out_act), 32'd0);
        chk("rst_out_wgt", 32'(out_wgt), 32'd0);
        chk("rst_out_pos", 32'(out_pos), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        resetn = 1'b1;
        tick();

        // Vector table
        for (int i = 0; i < 6; i++) begin
            beats_seen = 0;
            send(vecs[i].cnt, vecs[i].ia, vecs[i].iw);
            chk("vec_first_valid", 32'(out_valid), 32'd1);
            chk("vec_first_act", 32'(out_act), 32'(vecs[i].a0));
            chk("vec_first_wgt", 32'(out_wgt), 32'(vecs[i].w0));
            drain();
            chk("vec_nbeats", beats_seen, vecs[i].nbeats);
            tick();
        end

        // Basic block cycle-accurate timing
        send(4'd3, pk(0,2,5,0,0,0,0,0), pk(1,2,3,0,0,0,0,0));
        chk("bas1_act", 32'(out_act), 32'h10);
        chk("bas1_wgt", 32'(out_wgt), 32'h21);
        chk("bas1_last", 32'(out_last), 32'd0);
        chk("bas1_in_ready", 32'(in_ready), 32'd0);
        tick();
        chk("bas2_act", 32'(out_act), 32'h12);
        chk("bas2_pos", 32'(out_pos), 32'd1);
        chk("bas2_in_ready", 32'(in_ready), 32'd0);
        tick();
        chk("bas3_act", 32'(out_act), 32'h15);
        chk("bas3_wgt", 32'(out_wgt), 32'h23);
        chk("bas3_last", 32'(out_last), 32'd1);
`ifdef OPERAND_STREAMER_PREFETCH_EN
        chk("bas3_in_ready", 32'(in_ready), 32'd1);
`else
        chk("bas3_in_ready", 32'(in_ready), 32'd0);
`endif
        tick();
        chk("bas_idle_valid", 32'(out_valid), 32'd0);
        chk("bas_idle_ready", 32'(in_ready), 32'd1);

        // Backpressure on beat 1
        beats_seen = 0;
        send(4'd3, pk(0,2,5,0,0,0,0,0), pk(1,2,3,0,0,0,0,0));
        tick();
        out_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            tick();
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_act", 32'(out_act), 32'h12);
            chk("bp_wgt", 32'(out_wgt), 32'h22);
            chk("bp_pos", 32'(out_pos), 32'd1);
            chk("bp_last", 32'(out_last), 32'd0);
        end
        out_ready = 1'b1;
        tick();
        chk("bp_next_pos", 32'(out_pos), 32'd2);
        chk("bp_next_act", 32'(out_act), 32'h15);
        drain();
        chk("bp_nbeats", beats_seen, 3);
        tick();

        // Reset mid-stream
        send(4'd3, pk(0,2,5,0,0,0,0,0), pk(1,2,3,0,0,0,0,0));
        tick();
        resetn = 1'b0;
        #1;
        chk("mrst_valid", 32'(out_valid), 32'd0);
        sb.delete();
        tick();
        resetn = 1'b1;
        chk("mrst_in_ready", 32'(in_ready), 32'd1);
        begin
            int resid;
            resid = 0;
            for (int c = 0; c < 5; c++) begin
                tick();
                if (out_valid) resid++;
            end
            chk("mrst_residual", resid, 0);
        end

        // Back-to-back two-pair blocks
        vhist.delete();
        beats_seen = 0;
        send(4'd2, pk(1,3,0,0,0,0,0,0), pk(2,4,0,0,0,0,0,0));
        rec_en = 1'b1;
        send(4'd2, pk(5,6,0,0,0,0,0,0), pk(7,0,0,0,0,0,0,0));
        drain();
        tick();
        rec_en = 1'b0;
        chk("b2b_nbeats", beats_seen, 4);
        begin
            logic exp_v [5];
`ifdef OPERAND_STREAMER_PREFETCH_EN
            exp_v = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
`else
            exp_v = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
`endif
            for (int c = 0; c < 5; c++) begin
                if (c < vhist.size())
                    chk("b2b_valid_pattern", 32'(vhist[c]), 32'(exp_v[c]));
                else
                    chk("b2b_hist_len", vhist.size(), 5);
            end
        end

        chk("sb_empty_end", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
